// File: rtl/gate_sweep_ctrl_if.sv
// gate_sweep_ctrl_if
//
// Signal bundle between the gate sweep sequencer and the rest of the system.
// Groups the sweep request, the gate stimulus/response pair and the status
// outputs. The clock and reset stay plain ports on the modules.
//
//   start     : sweep request from bring-up/self-test logic
//   a, b      : gate inputs driven by the sequencer
//   and_out   : gate block response a & b
//   or_out    : gate block response a | b
//   not_out   : gate block response ~a
//   busy      : sweep in progress
//   done      : sweep complete (level)
//   pass      : all four vectors matched (valid with done)
//   vec_idx   : index of the vector currently applied
//   fail_mask : per-vector mismatch flags
//   err_count : number of failing vectors
//
// master : the sequencer side
// slave  : the environment side (gate block plus requester)

interface gate_sweep_ctrl_if;

   logic       start;
   logic       a;
   logic       b;
   logic       and_out;
   logic       or_out;
   logic       not_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [1:0] vec_idx;
   logic [3:0] fail_mask;
   logic [2:0] err_count;

   modport master (
      input  start,
      input  and_out,
      input  or_out,
      input  not_out,
      output a,
      output b,
      output busy,
      output done,
      output pass,
      output vec_idx,
      output fail_mask,
      output err_count
   );

   modport slave (
      output start,
      output and_out,
      output or_out,
      output not_out,
      input  a,
      input  b,
      input  busy,
      input  done,
      input  pass,
      input  vec_idx,
      input  fail_mask,
      input  err_count
   );

endinterface

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl
//
// Self-checking sweep sequencer for the two-input gate datapath. Applies the
// vectors ab = 00, 01, 10, 11 in order, holds each one for HOLD_CYCLES cycles,
// then spends one cycle comparing and_out/or_out/not_out against a&b, a|b, ~a.
// Mismatching vectors are flagged in fail_mask and counted in err_count; after
// the last vector the block parks in DONE with pass = (fail_mask == 0).
//
// Parameters
//   HOLD_CYCLES : cycles each vector is held before sampling (>= 1)
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : gate_sweep_ctrl_if master modport (start, gate stimulus/response,
//           busy/done/pass/vec_idx/fail_mask/err_count status)

module gate_sweep_ctrl #(
   parameter int unsigned HOLD_CYCLES = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   gate_sweep_ctrl_if.master  bus
);

   // Counter must be able to hold HOLD_CYCLES; never narrower than one bit.
   localparam int unsigned CntW =
      ($clog2(HOLD_CYCLES + 1) > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StApply,
      StSample,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      vec_q, vec_d;
   logic [3:0]      mask_q, mask_d;
   logic [2:0]      err_q, err_d;
   logic            pass_q, pass_d;

   logic            exp_and;
   logic            exp_or;
   logic            exp_not;
   logic            mismatch;

   // Expected gate responses for the vector currently on a/b.
   always_comb begin
      exp_and  = vec_q[1] & vec_q[0];
      exp_or   = vec_q[1] | vec_q[0];
      exp_not  = ~vec_q[1];
      mismatch = (bus.and_out != exp_and) |
                 (bus.or_out  != exp_or)  |
                 (bus.not_out != exp_not);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      mask_d  = mask_q;
      err_d   = err_q;
      pass_d  = pass_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               mask_d  = 4'b0000;
               err_d   = 3'd0;
               pass_d  = 1'b0;
               vec_d   = 2'd0;
               cnt_d   = '0;
               state_d = StApply;
            end
         end

         StApply: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = StSample;
            end
         end

         StSample: begin
            cnt_d = '0;
            // Guard on the existing flag so a vector is never counted twice.
            if (mismatch && !mask_q[vec_q]) begin
               mask_d[vec_q] = 1'b1;
               err_d         = err_q + 3'd1;
            end
            if (vec_q == 2'd3) begin
               pass_d  = (mask_d == 4'b0000);
               state_d = StDone;
            end else begin
               vec_d   = vec_q + 2'd1;
               state_d = StApply;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         vec_q   <= 2'd0;
         mask_q  <= 4'b0000;
         err_q   <= 3'd0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
      end
   end

   // Status decoded from registered state only, so reset clears it at once.
   assign bus.a         = vec_q[1];
   assign bus.b         = vec_q[0];
   assign bus.busy      = (state_q == StApply) || (state_q == StSample);
   assign bus.done      = (state_q == StDone);
   assign bus.pass      = pass_q;
   assign bus.vec_idx   = vec_q;
   assign bus.fail_mask = mask_q;
   assign bus.err_count = err_q;

   busy_done_exclusive: assert property (
      @(posedge clk) disable iff (!rst_n) !(bus.busy && bus.done)
   );

   err_count_matches_mask: assert property (
      @(posedge clk) disable iff (!rst_n)
         bus.err_count == 3'($countones(bus.fail_mask))
   );

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl
//
// Directed bench for gate_sweep_ctrl. Two instances are built, one with the
// default hold of 10 cycles and one with the minimum hold of 1. A behavioural
// gate block with selectable faults answers each instance. A table of
// {fault, expected fail_mask, err_count, pass} records drives full sweeps on
// both instances; hand-written sequences cover reset and start handling.

module tb_gate_sweep_ctrl;

   logic clk;
   logic rst_n;

   gate_sweep_ctrl_if if10 ();
   gate_sweep_ctrl_if if1 ();

   gate_sweep_ctrl #(.HOLD_CYCLES(10)) dut10 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if10)
   );

   gate_sweep_ctrl #(.HOLD_CYCLES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0 good, 1 or_out stuck at 0, 2 not_out is a buffer, 3 and_out wrong on ab=01
   int fault;

   function automatic logic [2:0] gate_model(input logic a, input logic b, input int f);
      logic g_and, g_or, g_not;
      g_and = a & b;
      g_or  = a | b;
      g_not = ~a;
      if (f == 1) g_or = 1'b0;
      if (f == 2) g_not = a;
      if (f == 3 && !a && b) g_and = ~g_and;
      return {g_and, g_or, g_not};
   endfunction

   always_comb {if10.and_out, if10.or_out, if10.not_out} = gate_model(if10.a, if10.b, fault);
   always_comb {if1.and_out, if1.or_out, if1.not_out} = gate_model(if1.a, if1.b, fault);

   // Status word: [13]a [12]b [11]busy [10]done [9]pass [8:7]vec [6:3]mask [2:0]err
   logic [13:0] st10, st1;
   assign st10 = {if10.a, if10.b, if10.busy, if10.done, if10.pass, if10.vec_idx,
                  if10.fail_mask, if10.err_count};
   assign st1  = {if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.vec_idx,
                  if1.fail_mask, if1.err_count};

   bit sel;  // 0 selects the HOLD_CYCLES=10 instance, 1 the HOLD_CYCLES=1 one
   int tests;
   int fails;

   function automatic logic [13:0] cur();
      return sel ? st1 : st10;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) if1.start = v;
      else     if10.start = v;
   endtask

   // Accept a start, then run to done. cyc counts edges after the accepting
   // edge. trace checks a/b/busy/done every cycle; pulse_at >= 0 pulses start
   // for one cycle at that point in the sweep.
   task automatic sweep(input bit trace, input int pulse_at, output int cyc);
      int         hold;
      logic [1:0] kk;
      hold = sel ? 1 : 10;
      @(negedge clk);
      set_start(1'b1);
      @(posedge clk);
      @(negedge clk);
      set_start(1'b0);
      cyc = 0;
      check("accept_state", 32'(cur()), 32'({2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 3'd0}));
      while (!cur()[10] && cyc < 200) begin
         set_start(cyc == pulse_at);
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (trace && !cur()[10]) begin
            kk = 2'(cyc / (hold + 1));
            check("trace_ab_busy", 32'(cur()[13:10]), 32'({kk, 1'b1, 1'b0}));
         end
      end
      set_start(1'b0);
      if (!cur()[10]) check("done_timeout", 32'(cur()[10]), 32'd1);
   endtask

   typedef struct {
      int         f;
      logic [3:0] mask;
      logic [2:0] errs;
      logic       pass;
   } vec_t;

   vec_t vt[4];

   initial begin
      int cyc;
      int guard;

      vt[0] = '{f: 0, mask: 4'b0000, errs: 3'd0, pass: 1'b1};
      vt[1] = '{f: 1, mask: 4'b1110, errs: 3'd3, pass: 1'b0};
      vt[2] = '{f: 2, mask: 4'b1111, errs: 3'd4, pass: 1'b0};
      vt[3] = '{f: 3, mask: 4'b0010, errs: 3'd1, pass: 1'b0};

      tests      = 0;
      fails      = 0;
      fault      = 0;
      sel        = 1'b0;
      if10.start = 1'b0;
      if1.start  = 1'b0;
      rst_n      = 1'b0;

      // Reset is asserted before the first edge: outputs must already be zero.
      #2;
      check("reset_async_10", 32'(st10), 32'd0);
      check("reset_async_1", 32'(st1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_no_start", 32'({st10, st1}), 32'd0);
      end

      // Good gate block, hold 10: full trace and done at edge 44.
      sel   = 1'b0;
      fault = 0;
      sweep(1'b1, -1, cyc);
      check("done_latency_10", 32'(cyc), 32'd44);
      check("good_final_10", 32'(st10), 32'({2'b11, 1'b0, 1'b1, 1'b1, 2'b11, 4'b0000, 3'd0}));

      // Fault table on both hold settings.
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         for (int i = 0; i < 4; i++) begin
            fault = vt[i].f;
            sweep(1'b0, -1, cyc);
            check("table_latency", 32'(cyc), (s == 1) ? 32'd8 : 32'd44);
            check("table_result", 32'({cur()[9], cur()[6:0]}),
                  32'({vt[i].pass, vt[i].mask, vt[i].errs}));
         end
      end
      fault = 0;

      // Reset after DONE clears everything without a clock edge.
      sel = 1'b0;
      sweep(1'b0, -1, cyc);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_after_done", 32'(st10), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-sweep at vec_idx = 2.
      @(negedge clk);
      if10.start = 1'b1;
      @(negedge clk);
      if10.start = 1'b0;
      guard = 0;
      while (if10.vec_idx != 2'd2 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("reach_vec2", 32'(if10.vec_idx), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_mid_sweep", 32'(st10), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_reset", 32'(st10), 32'd0);
      sweep(1'b1, -1, cyc);
      check("rerun_latency", 32'(cyc), 32'd44);
      check("rerun_pass", 32'({st10[9], st10[6:0]}), 32'({1'b1, 4'b0000, 3'd0}));

      // Hold 1: start pulsed while busy is ignored.
      sel   = 1'b1;
      fault = 0;
      sweep(1'b1, 3, cyc);
      check("busy_start_latency", 32'(cyc), 32'd8);
      check("busy_start_result", 32'({st1[9], st1[6:0]}), 32'({1'b1, 4'b0000, 3'd0}));

      // Start in DONE with fail_mask 0010: flags clear on accept, sweep reruns.
      fault = 3;
      sweep(1'b0, -1, cyc);
      check("mask_0010", 32'(st1[6:0]), 32'({4'b0010, 3'd1}));
      fault = 0;
      sweep(1'b1, -1, cyc);
      check("restart_latency", 32'(cyc), 32'd8);
      check("restart_result", 32'({st1[9], st1[6:0]}), 32'({1'b1, 4'b0000, 3'd0}));

      // Start held high: DONE lasts one cycle, then a new sweep begins.
      @(negedge clk);
      if1.start = 1'b1;
      guard = 0;
      while (!if1.done && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("held_start_done", 32'(if1.done), 32'd1);
      @(negedge clk);
      check("held_start_rerun", 32'(st1[11:0]), 32'({1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 3'd0}));
      if1.start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
